rr_arbiter8: RTL and testbench

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/rr_arbiter8_pkg.sv | 20 ++
 rtl/rr_pick8.sv | 29 ++
 rtl/rr_arbiter8.sv | 89 ++++++++
 tb/tb_rr_arbiter8.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter8_pkg.sv
// rtl/rr_arbiter8_pkg.sv - shared types and constants for the 8-way round-robin arbiter
package rr_arbiter8_pkg;

    localparam int NREQ = 8;
    localparam int IDXW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Same bit ordering as a dec3x8: sel=i drives output bit i.
    function automatic logic [NREQ-1:0] dec3x8(input logic [IDXW-1:0] sel);
        logic [NREQ-1:0] y;
        y      = '0;
        y[sel] = 1'b1;
        return y;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - rotating-priority search: first set req bit at ptr, ptr+1, ... ptr+7
module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDXW-1:0]   off;

    always_comb begin
        // rot[i] is req[(ptr+i) mod 8]; lowest set bit of rot is the winner's offset
        dbl = {req, req};
        rot = dbl[ptr +: NREQ];
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDXW'(i);
            end
        end
        idx = ptr + off;
        any = |req;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-requester round-robin arbiter with hold-time limit and done release
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t          state, state_n;
    logic [IDXW-1:0] ptr, ptr_n;
    logic [IDXW-1:0] idx_n;
    logic [HW-1:0]   hold_cnt, hold_n;
    logic [IDXW-1:0] pick_ptr, pick_idx;
    logic            pick_any;
    logic            release_now;

    // While granting, search from owner+1 so the owner itself is considered last.
    assign pick_ptr = (state == GRANT) ? gnt_idx + IDXW'(1) : ptr;

    rr_pick8 u_pick (
        .req (req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign release_now = (state == GRANT) &&
                         (done || !req[gnt_idx] || (hold_cnt == HOLD_LAST));

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        idx_n   = gnt_idx;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n = GRANT;
                    idx_n   = pick_idx;
                    hold_n  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_n  = pick_ptr;
                    hold_n = '0;
                    if (pick_any) begin
                        idx_n = pick_idx;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    hold_n = hold_cnt + HW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt_idx  <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            gnt_idx  <= idx_n;
            hold_cnt <= hold_n;
        end
    end

    assign gnt_valid = (state == GRANT);
    assign gnt       = gnt_valid ? dec3x8(gnt_idx) : '0;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - self-checking bench for rr_arbiter8 against a behavioural model
module tb_rr_arbiter8;

    localparam int MH    = 4;
    localparam int BOUND = 7 * MH + 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req   = 8'h00;
    logic       done  = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int n_tests = 0;
    int n_fail  = 0;

    bit m_valid;
    int m_owner;
    int m_ptr;
    int m_held;

    rr_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    function automatic int search(input logic [7:0] r, input int p);
        for (int off = 0; off < 8; off++) begin
            if (r[(p + off) % 8]) return (p + off) % 8;
        end
        return -1;
    endfunction

    function automatic logic [7:0] m_gnt();
        logic [7:0] one;
        one = 8'h01;
        return m_valid ? (one << m_owner) : 8'h00;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_held  = 0;
    endtask

    // m_held counts cycles the current owner has been shown as granted (1 on first cycle)
    task automatic model_step();
        if (!m_valid) begin
            if (req != 8'h00) begin
                m_owner = search(req, m_ptr);
                m_valid = 1'b1;
                m_held  = 1;
            end
        end else if (done || !req[m_owner] || m_held == MH) begin
            m_ptr = (m_owner + 1) % 8;
            if (req != 8'h00) begin
                m_owner = search(req, m_ptr);
                m_held  = 1;
            end else begin
                m_valid = 1'b0;
            end
        end else begin
            m_held++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #3;
        model_reset();
        n_tests++;
        if (gnt !== 8'h00) begin n_fail++; $display("FAIL reset_gnt got %h want 00", gnt); end
        n_tests++;
        if (gnt_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", gnt_idx); end
        n_tests++;
        if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", gnt_valid); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req = 8'h04;
        tick();
        n_tests++;
        if (gnt !== 8'h04 || gnt_idx !== 3'd2 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant got gnt=%h idx=%0d v=%b want 04/2/1", gnt, gnt_idx, gnt_valid);
        end
        req = 8'h00;
        tick();
        n_tests++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd2) begin
            n_fail++;
            $display("FAIL single_release got gnt=%h idx=%0d v=%b want 00/2/0", gnt, gnt_idx, gnt_valid);
        end
        n_tests++;
        if (dut.ptr !== 3'd3) begin n_fail++; $display("FAIL single_ptr got %0d want 3", dut.ptr); end
        req = 8'h09;
        tick();
        n_tests++;
        if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin
            n_fail++;
            $display("FAIL single_from_ptr got gnt=%h idx=%0d want 08/3", gnt, gnt_idx);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_done_rotation();
        do_reset();
        req = 8'hFF;
        tick();
        for (int k = 0; k < 27; k++) begin
            n_tests++;
            if (gnt_idx !== 3'((k / 3) % 8) || gnt_valid !== 1'b1 || gnt !== m_gnt()) begin
                n_fail++;
                $display("FAIL rotation k=%0d got idx=%0d v=%b gnt=%h want idx=%0d v=1 gnt=%h",
                         k, gnt_idx, gnt_valid, gnt, (k / 3) % 8, m_gnt());
            end
            done = (k % 3 == 2);
            tick();
        end
        done = 1'b0;
        req  = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        int exp_idx;
        do_reset();
        req = 8'h81;
        tick();
        for (int k = 0; k < 12; k++) begin
            exp_idx = (k < 4 || k >= 8) ? 0 : 7;
            n_tests++;
            if (gnt_idx !== 3'(exp_idx) || gnt_valid !== 1'b1 || gnt !== m_gnt()) begin
                n_fail++;
                $display("FAIL timeout k=%0d got idx=%0d v=%b want idx=%0d v=1", k, gnt_idx, gnt_valid, exp_idx);
            end
            tick();
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_sole();
        do_reset();
        req = 8'h10;
        tick();
        for (int k = 0; k < 10; k++) begin
            n_tests++;
            if (gnt !== 8'h10 || gnt_valid !== 1'b1 || dut.hold_cnt !== 2'(k % 4)) begin
                n_fail++;
                $display("FAIL sole k=%0d got gnt=%h v=%b hold=%0d want 10/1/%0d",
                         k, gnt, gnt_valid, dut.hold_cnt, k % 4);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        req = 8'hFF;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset got gnt=%h v=%b idx=%0d want 00/0/0", gnt, gnt_valid, gnt_idx);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'hFF;
        tick();
        n_tests++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset got gnt=%h idx=%0d v=%b want 01/0/1", gnt, gnt_idx, gnt_valid);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_random();
        int wait_cnt [8];
        int worst;
        logic [7:0] flip;
        for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
        req = 8'($urandom);
        for (int c = 0; c < 10000; c++) begin
            done = ($urandom_range(5) == 0);
            tick();
            n_tests++;
            if (gnt !== m_gnt() || gnt_valid !== m_valid || gnt_idx !== 3'(m_owner)) begin
                n_fail++;
                $display("FAIL random_model c=%0d got gnt=%h idx=%0d v=%b want gnt=%h idx=%0d v=%b",
                         c, gnt, gnt_idx, gnt_valid, m_gnt(), m_owner, m_valid);
            end
            n_tests++;
            if (!$onehot0(gnt) || gnt[gnt_idx] !== gnt_valid) begin
                n_fail++;
                $display("FAIL random_onehot c=%0d got gnt=%h idx=%0d v=%b", c, gnt, gnt_idx, gnt_valid);
            end
            worst = 0;
            for (int i = 0; i < 8; i++) begin
                if (req[i] && !gnt[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > worst) worst = wait_cnt[i];
            end
            n_tests++;
            if (worst > BOUND || m_held > MH) begin
                n_fail++;
                $display("FAIL random_bound c=%0d got wait=%0d held=%0d want wait<=%0d held<=%0d",
                         c, worst, m_held, BOUND, MH);
            end
            flip = 8'h00;
            for (int i = 0; i < 8; i++) flip[i] = ($urandom_range(7) == 0);
            req = req ^ flip;
        end
        done = 1'b0;
        req  = 8'h00;
        tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_done_rotation();
        test_timeout();
        test_sole();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
